// File: rtl/program_sequencer.sv
// MiniCPU program sequencer: fetches {opcode, operand} words from synchronous program
// memory and issues each opcode for one cycle, with free-run and single-step modes.
module program_sequencer #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 4,
  parameter int PROG_LEN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                step_mode,
  input  logic                step,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [4+DATA_W-1:0] mem_rdata,
  output logic [3:0]          instruction,
  output logic [DATA_W-1:0]   data_out,
  output logic                instr_valid,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   pc,
  output logic [3:0]          err_op
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_ISSUE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);
  localparam logic [3:0]        FIRST_RESERVED_OP = 4'd12;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [3:0]          ir_op_reg;
  logic [DATA_W-1:0]   ir_arg_reg;
  logic [3:0]          instr_reg, instr_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic [3:0]          err_op_reg, err_op_next;
  logic                step_hold;

  // In single-step mode DECODE waits until step is seen high.
  assign step_hold = step_mode && !step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      pc_reg     <= '0;
      instr_reg  <= '0;
      data_reg   <= '0;
      err_op_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      data_reg   <= data_next;
      err_op_reg <= err_op_next;
    end
  end

  // Memory data is valid in WAIT, one cycle after the FETCH read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_op_reg  <= '0;
      ir_arg_reg <= '0;
    end else if (state_reg == S_WAIT) begin
      ir_op_reg  <= mem_rdata[4+DATA_W-1:DATA_W];
      ir_arg_reg <= mem_rdata[DATA_W-1:0];
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    data_next   = data_reg;
    err_op_next = err_op_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next  = S_FETCH;
          pc_next     = '0;
          err_op_next = '0;
        end
      end
      S_FETCH: state_next = S_WAIT;
      S_WAIT:  state_next = S_DECODE;
      S_DECODE: begin
        if (ir_op_reg >= FIRST_RESERVED_OP) begin
          state_next  = S_ERROR;
          err_op_next = ir_op_reg;
        end else if (!step_hold) begin
          // Load the issue registers here so they are stable throughout ISSUE and hold afterwards.
          state_next = S_ISSUE;
          instr_next = ir_op_reg;
          data_next  = ir_arg_reg;
        end
      end
      S_ISSUE: begin
        if (pc_reg == LAST_PC) begin
          state_next = S_DONE;
        end else begin
          state_next = S_FETCH;
          pc_next    = pc_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign mem_rd      = (state_reg == S_FETCH);
  assign mem_addr    = pc_reg;
  assign instruction = instr_reg;
  assign data_out    = data_reg;
  assign instr_valid = (state_reg == S_ISSUE);
  assign busy        = (state_reg == S_FETCH) || (state_reg == S_WAIT) ||
                       (state_reg == S_DECODE) || (state_reg == S_ISSUE);
  assign done        = (state_reg == S_DONE);
  assign err         = (state_reg == S_ERROR);
  assign pc          = pc_reg;
  assign err_op      = err_op_reg;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: a 3-word instance and a 16-word instance,
// each with its own synchronous program memory model.
module tb_program_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, step_mode, step, start3, start16;

  logic       mem_rd3, iv3, busy3, done3, err3;
  logic [3:0] mem_addr3, instr3, data3, pc3, err_op3;
  logic [7:0] rdata3 = '0;
  logic       mem_rd16, iv16, busy16, done16, err16;
  logic [3:0] mem_addr16, instr16, data16, pc16, err_op16;
  logic [7:0] rdata16 = '0;

  logic [7:0] mem3  [16];
  logic [7:0] mem16 [16];

  program_sequencer #(.DATA_W(4), .ADDR_W(4), .PROG_LEN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .step_mode(step_mode), .step(step),
    .mem_rd(mem_rd3), .mem_addr(mem_addr3), .mem_rdata(rdata3),
    .instruction(instr3), .data_out(data3), .instr_valid(iv3), .busy(busy3),
    .done(done3), .err(err3), .pc(pc3), .err_op(err_op3));

  program_sequencer #(.DATA_W(4), .ADDR_W(4), .PROG_LEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .step_mode(step_mode), .step(step),
    .mem_rd(mem_rd16), .mem_addr(mem_addr16), .mem_rdata(rdata16),
    .instruction(instr16), .data_out(data16), .instr_valid(iv16), .busy(busy16),
    .done(done16), .err(err16), .pc(pc16), .err_op(err_op16));

  always @(posedge clk) begin
    if (mem_rd3)  rdata3  <= mem3[mem_addr3];
    if (mem_rd16) rdata16 <= mem16[mem_addr16];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] w;
    int         at;   // expected issue cycle, -1 = not timed
  } exp_t;
  exp_t q3[$];
  exp_t q16[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic logic [7:0] progb(input int i);
    return {4'(i % 12), 4'((i * 3 + 1) % 16)};
  endfunction

  // Monitor: pops the scoreboard whenever a strobe is presented.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (iv3) begin
      if (q3.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL dut3 stray strobe: got instr %0d data %0d, required no strobe", instr3, data3);
      end else begin
        e = q3.pop_front();
        check("dut3 issued word", 32'({instr3, data3}), 32'(e.w));
        if (e.at >= 0) check("dut3 issue cycle", 32'(cyc), 32'(e.at));
      end
    end
    if (iv16) begin
      if (q16.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL dut16 stray strobe: got instr %0d data %0d, required no strobe", instr16, data16);
      end else begin
        e = q16.pop_front();
        check("dut16 issued word", 32'({instr16, data16}), 32'(e.w));
        if (e.at >= 0) check("dut16 issue cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic push(input bit use16, input logic [7:0] w, input int at);
    exp_t e;
    e.w = w; e.at = at;
    if (use16) q16.push_back(e); else q3.push_back(e);
  endtask

  task automatic pulse_start(input bit use16);
    if (use16) start16 = 1'b1; else start3 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; start3 = 1'b0;
  endtask

  // Waits for done or err; gaps counts cycles where busy was low before completion.
  task automatic wait_end(input bit use16, input int budget, output int when, output int gaps);
    when = -1; gaps = 0;
    for (int i = 0; i < budget && when < 0; i++) begin
      @(negedge clk);
      if (use16 ? (done16 | err16) : (done3 | err3)) when = cyc;
      else if (!(use16 ? busy16 : busy3)) gaps++;
    end
    if (when < 0) begin
      vectors++; miscompares++;
      $display("FAIL wait_end: got no done/err within %0d cycles, required completion", budget);
    end
  endtask

  int base, when, gaps, seen;

  initial begin
    rst_n = 1'b0; start3 = 1'b0; start16 = 1'b0; step = 1'b0; step_mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem3[i]  = 8'h00;
      mem16[i] = progb(i);
    end
    mem3[0] = 8'h15; mem3[1] = 8'h23; mem3[2] = 8'h40;

    repeat (2) @(negedge clk);
    check("reset outputs dut3", 32'({mem_rd3, mem_addr3, instr3, data3, iv3, busy3, done3, err3, pc3, err_op3}), 0);
    check("reset outputs dut16", 32'({mem_rd16, mem_addr16, instr16, data16, iv16, busy16, done16, err16, pc16, err_op16}), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle without start busy3", 32'(busy3), 0);

    // Three-word program: strobes at cycles 4, 8, 12, done from 13.
    base = cyc;
    push(0, 8'h15, base + 4); push(0, 8'h23, base + 8); push(0, 8'h40, base + 12);
    pulse_start(0);
    wait_end(0, 40, when, gaps);
    check("t1 done cycle", 32'(when - base), 13);
    check("t1 pc", 32'(pc3), 2);
    check("t1 err", 32'(err3), 0);
    check("t1 busy gaps", 32'(gaps), 0);

    // Restart from DONE with start held during execution; trace must be identical.
    repeat (3) @(negedge clk);
    check("t1 done holds", 32'(done3), 1);
    base = cyc;
    push(0, 8'h15, base + 4); push(0, 8'h23, base + 8); push(0, 8'h40, base + 12);
    pulse_start(0);
    @(negedge clk);
    start3 = 1'b1;
    repeat (4) @(negedge clk);
    start3 = 1'b0;
    wait_end(0, 40, when, gaps);
    check("t6 rerun done cycle", 32'(when - base), 13);
    check("t6 rerun pc", 32'(pc3), 2);

    // Sixteen-word free run.
    base = cyc;
    for (int i = 0; i < 16; i++) push(1, progb(i), base + 4 + 4 * i);
    pulse_start(1);
    wait_end(1, 100, when, gaps);
    check("t2 done cycle", 32'(when - base), 65);
    check("t2 busy gaps", 32'(gaps), 0);
    check("t2 done", 32'(done16), 1);
    check("t2 err", 32'(err16), 0);
    check("t2 pc", 32'(pc16), 15);

    // Reserved opcode at word 1.
    mem16[1] = 8'hD7;
    base = cyc;
    push(1, progb(0), base + 4);
    pulse_start(1);
    wait_end(1, 40, when, gaps);
    check("t3 error cycle", 32'(when - base), 8);
    check("t3 err", 32'(err16), 1);
    check("t3 err_op", 32'(err_op16), 13);
    check("t3 pc", 32'(pc16), 1);
    check("t3 done", 32'(done16), 0);
    repeat (10) @(negedge clk);
    check("t3 err_op held", 32'({err16, err_op16}), 32'({1'b1, 4'd13}));
    mem16[1] = progb(1);
    base = cyc;
    for (int i = 0; i < 16; i++) push(1, progb(i), base + 4 + 4 * i);
    pulse_start(1);
    check("t3 restart clears err", 32'({err16, err_op16, pc16}), 0);
    wait_end(1, 100, when, gaps);
    check("t3 restart done cycle", 32'(when - base), 65);

    // Single-step: parked in DECODE until each one-cycle step pulse.
    step_mode = 1'b1;
    pulse_start(1);
    repeat (20) @(negedge clk);
    check("t4 hold pc", 32'(pc16), 0);
    check("t4 hold no strobe", 32'(iv16), 0);
    check("t4 hold busy", 32'(busy16), 1);
    for (int k = 0; k < 16; k++) begin
      push(1, progb(k), cyc + 1);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (5) @(negedge clk);
    end
    check("t4 done after steps", 32'(done16), 1);
    step_mode = 1'b0;

    // Asynchronous reset during the ISSUE cycle of instruction 2.
    base = cyc;
    push(1, progb(0), base + 4); push(1, progb(1), base + 8); push(1, progb(2), base + 12);
    pulse_start(1);
    seen = 0;
    for (int i = 0; i < 40 && seen < 3; i++) begin
      @(negedge clk);
      if (iv16) seen++;
    end
    check("t5 strobes before reset", 32'(seen), 3);
    #2 rst_n = 1'b0;
    #1 check("t5 async reset outputs", 32'({mem_rd16, mem_addr16, instr16, data16, iv16, busy16, done16, err16, pc16, err_op16}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t5 stays idle", 32'({busy16, done16, err16, mem_rd16, pc16}), 0);

    check("dut3 scoreboard drained", 32'(q3.size()), 0);
    check("dut16 scoreboard drained", 32'(q16.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Sequences the MiniCPU datapath.
- Fetches 4-bit opcodes plus operand data from a synchronous program memory and presents each opcode to the instruction decoder for exactly one cycle.
- Drives the operand onto the data bus for MOVE operations.
- Supports free-run and single-step execution, and halts with an error flag on reserved opcodes 12-15.

Parameters:
- DATA_W, 4, operand width (matches register/ALU width).
- ADDR_W, 4, program memory address width.
- PROG_LEN, 16, number of program words executed before done (1..2^ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin execution from address 0 (sampled in IDLE, DONE, ERROR).
- step_mode  in  1  1 = wait for step before each issue.
- step  in  1  single-step advance pulse (used only when step_mode=1).
- mem_rd  out  1  program memory read strobe.
- mem_addr  out  ADDR_W  program memory address.
- mem_rdata  in  4+DATA_W  {opcode[3:0], operand}; valid the cycle after mem_rd.
- instruction  out  4  opcode to decoder.
- data_out  out  DATA_W  operand to datapath input bus.
- instr_valid  out  1  issue strobe; datapath registers load only when high.
- busy  out  1  high in FETCH/WAIT/DECODE/ISSUE.
- done  out  1  level, high in DONE.
- err  out  1  level, high in ERROR.
- pc  out  ADDR_W  current program counter.
- err_op  out  4  offending opcode, captured on entry to ERROR.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - pc, mem_addr, instruction, data_out, err_op = 0.
  - mem_rd, instr_valid, busy, done, err = 0.
  - Takes effect immediately, including mid-program. No issue strobe is produced during or on exit from reset.
- IDLE: on start=1, pc<=0 and go to FETCH. Otherwise hold.
- FETCH (1 cycle): mem_rd=1, mem_addr=pc. Go to WAIT.
- WAIT (1 cycle): register mem_rdata into the internal IR. Go to DECODE.
- DECODE:
  - If IR opcode >= 12: err_op<=opcode, go to ERROR. No strobe is issued.
  - Else if step_mode=1 and step=0: hold in DECODE.
  - Else go to ISSUE.
  - step is level-sampled. A step held high for several cycles advances only one instruction, because the next DECODE is at least 3 cycles later. The bench drives 1-cycle pulses.
- ISSUE (1 cycle):
  - instruction=IR opcode, data_out=IR operand, instr_valid=1.
  - If pc==PROG_LEN-1, go to DONE and leave pc unchanged.
  - Else pc<=pc+1 and go to FETCH.
- Timing: free-run throughput is one instruction per 4 cycles. start-to-first-instr_valid latency is 4 cycles (FETCH, WAIT, DECODE, ISSUE).
- instruction/data_out hold their last issued values outside ISSUE. Consumers qualify with instr_valid only.
- DONE: done=1. On start=1, clear done, pc<=0, go to FETCH.
- ERROR: err=1, err_op held. On start=1, clear err and err_op, pc<=0, go to FETCH.
- start while busy is ignored.
- Changing step_mode mid-program takes effect at the next DECODE.
- pc never wraps. PROG_LEN=2^ADDR_W terminates at pc=2^ADDR_W-1.
- Opcode 0 (CLEAR) is issued like any other opcode; the sequencer does not reset itself.

Test Plan:
- Reset then start=1 with memory[0..2]={1,5},{2,3},{4,0} and PROG_LEN=3 -> instr_valid at cycles 4, 8, 12 with instruction/data_out = 1/5, 2/3, 4/0; done=1 from cycle 13; pc=2.
- Free-run over a 16-word program containing opcodes 0-11 -> exactly 16 one-cycle instr_valid pulses in order, busy high throughout, done asserted, no err.
- memory[1]={13,7} -> one strobe (word 0) only; err=1, err_op=13, pc=1, no instr_valid after entering ERROR; start then restarts from pc=0 with err cleared.
- step_mode=1, no step for 20 cycles -> sequencer holds in DECODE with instr_valid=0 and pc=0. Each single-cycle step pulse -> exactly one instr_valid one cycle later.
- rst_n asserted low during the ISSUE cycle of instruction 2 -> all outputs 0 asynchronously; after release, stays in IDLE until start.
- start pulsed while busy -> ignored, sequence unaffected. start in DONE -> re-execution from address 0 with identical output trace.
